// File: rtl/mul_div_unit_if.sv
// Start/Busy handshake and HI/LO read-out bundle between the EX stage and the
// multiply/divide unit. The abort line exists only when MDU_ABORT_EN is defined.
interface mul_div_unit_if;
    logic        en;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
`ifdef MDU_ABORT_EN
    logic        abort;
`endif
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

`ifdef MDU_ABORT_EN
    modport master (output en, op, A, B, abort, input Start, Busy, HI, LO);
    modport slave  (input en, op, A, B, abort, output Start, Busy, HI, LO);
`else
    modport master (output en, op, A, B, input Start, Busy, HI, LO);
    modport slave  (input en, op, A, B, output Start, Busy, HI, LO);
`endif
endinterface

// File: rtl/mul_div_unit.sv
// Iterative-latency multiply/divide unit with HI/LO registers (EX stage).
// The result is computed from A/B at the launch edge and held; the Busy
// period only models latency, after which HI/LO are committed.
// Optional feature macro: MDU_ABORT_EN adds an abort input that cancels an
// in-flight operation, a pending launch, or an MTHI/MTLO write.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no operation in flight; Start may launch, MTHI/MTLO write
// S_RUN  | operation in flight; counter counts down Busy cycles
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_ok;

    logic        abort_w;
    logic        is_md;
    logic        start;
    logic        launch;

    logic        signed_op;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

`ifdef MDU_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    assign is_md  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign start  = bus.en & is_md & ~busy;
    assign launch = start & ~abort_w;

    assign bus.Start = start;
    assign bus.Busy  = busy;
    assign bus.HI    = hi;
    assign bus.LO    = lo;

    // Launch-time arithmetic: one wide product and a sign-magnitude divider.
    // Dividing magnitudes sidesteps the 0x80000000 / -1 overflow case, and a
    // zero divisor is replaced by 1 because that result is never committed.
    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        div_zero  = (bus.B == 32'd0);
        a_ext     = signed_op ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
        b_ext     = signed_op ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
        prod      = a_ext * b_ext;
        a_neg     = signed_op & bus.A[31];
        b_neg     = signed_op & bus.B[31];
        a_mag     = a_neg ? (32'd0 - bus.A) : bus.A;
        b_mag     = div_zero ? 32'd1 : (b_neg ? (32'd0 - bus.B) : bus.B);
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem       = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Control FSM with registered Busy and the HI/LO architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_ok <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        if (is_div) begin
                            res_hi <= rem;
                            res_lo <= quot;
                            res_ok <= ~div_zero;
                            cnt    <= 4'(DIV_CYCLES);
                        end else begin
                            res_hi <= prod[63:32];
                            res_lo <= prod[31:0];
                            res_ok <= 1'b1;
                            cnt    <= 4'(MULT_CYCLES);
                        end
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else if (bus.en && !abort_w) begin
                        if (bus.op == OP_MTHI) hi <= bus.A;
                        if (bus.op == OP_MTLO) lo <= bus.A;
                    end
                end
                S_RUN: begin
                    if (abort_w) begin
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == 4'd1) begin
                        if (res_ok) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
